// File: rtl/duty_cycle_meter_mc_if.sv
// Control, measured-signal and result bundle of the multi-channel duty-cycle meter.
// The master side drives control and ring_in; the slave side (the meter) returns results.
interface duty_cycle_meter_mc_if #(
    parameter int CHANNELS = 4,
    parameter int VALUE_W  = 17
);
    logic                          enable;
    logic                          mode;
    logic                          start;
    logic [CHANNELS-1:0]           ring_in;
    logic [CHANNELS*VALUE_W-1:0]   value;
    logic                          valid;
    logic                          busy;
    logic [CHANNELS-1:0]           stuck;

    modport master (
        output enable, mode, start, ring_in,
        input  value, valid, busy, stuck
    );

    modport slave (
        input  enable, mode, start, ring_in,
        output value, valid, busy, stuck
    );
endinterface

// File: rtl/duty_cycle_meter_mc.sv
// Counts synchronised high cycles per channel over a fixed window and flags channels
// that never toggled; continuous or single-shot operation.
module duty_cycle_meter_mc #(
    parameter int CHANNELS = 4,
    parameter int WINDOW   = 65536,
    parameter int VALUE_W  = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    duty_cycle_meter_mc_if.slave bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [VALUE_W-1:0]  CNT_ZERO = {VALUE_W{1'b0}};
    localparam logic [VALUE_W-1:0]  LAST_CNT = VALUE_W'(WINDOW - 1);
    localparam logic [CHANNELS-1:0] CH_ZERO  = {CHANNELS{1'b0}};

    state_t                      state_r;
    logic [CHANNELS-1:0]         sync1_r;
    logic [CHANNELS-1:0]         sync2_r;
    logic [CHANNELS-1:0]         prev_r;
    logic [CHANNELS-1:0]         edge_seen_r;
    logic [CHANNELS-1:0]         stuck_r;
    logic [VALUE_W-1:0]          win_cnt_r;
    logic [VALUE_W-1:0]          hi_cnt_r [CHANNELS];
    logic [CHANNELS*VALUE_W-1:0] value_r;
    logic                        valid_r;
    logic                        busy_r;
    logic [CHANNELS-1:0]         edge_s;

    // Adds a single sample bit to a counter without widening the result.
    function automatic logic [VALUE_W-1:0] add_bit(input logic [VALUE_W-1:0] acc,
                                                   input logic               b);
        return acc + {{(VALUE_W-1){1'b0}}, b};
    endfunction

    assign edge_s = sync2_r ^ prev_r;

    // Synchroniser and edge history run regardless of FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= CH_ZERO;
            sync2_r <= CH_ZERO;
            prev_r  <= CH_ZERO;
        end else begin
            sync1_r <= bus.ring_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Window FSM, per-channel accumulators and registered results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            win_cnt_r   <= CNT_ZERO;
            edge_seen_r <= CH_ZERO;
            value_r     <= {(CHANNELS*VALUE_W){1'b0}};
            stuck_r     <= CH_ZERO;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                hi_cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.enable && (!bus.mode || bus.start)) begin
                        state_r     <= MEASURE;
                        busy_r      <= 1'b1;
                        win_cnt_r   <= CNT_ZERO;
                        edge_seen_r <= CH_ZERO;
                        for (int i = 0; i < CHANNELS; i++) begin
                            hi_cnt_r[i] <= CNT_ZERO;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (!bus.enable) begin
                        // Abort: partial window is dropped, previous results stay visible.
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (win_cnt_r == LAST_CNT) begin
                        // Last sample is folded in directly so the next window starts gap-free.
                        for (int i = 0; i < CHANNELS; i++) begin
                            value_r[i*VALUE_W +: VALUE_W] <= add_bit(hi_cnt_r[i], sync2_r[i]);
                            hi_cnt_r[i]                   <= CNT_ZERO;
                        end
                        stuck_r     <= ~(edge_seen_r | edge_s);
                        valid_r     <= 1'b1;
                        win_cnt_r   <= CNT_ZERO;
                        edge_seen_r <= CH_ZERO;
                        if (bus.mode) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= MEASURE;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            hi_cnt_r[i] <= add_bit(hi_cnt_r[i], sync2_r[i]);
                        end
                        edge_seen_r <= edge_seen_r | edge_s;
                        win_cnt_r   <= add_bit(win_cnt_r, 1'b1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.value = value_r;
    assign bus.valid = valid_r;
    assign bus.busy  = busy_r;
    assign bus.stuck = stuck_r;
endmodule

// File: tb/tb_duty_cycle_meter_mc.sv
// Scoreboard bench for duty_cycle_meter_mc with a 16-cycle window and four channels.
module tb_duty_cycle_meter_mc;
    localparam int CH  = 4;
    localparam int VW  = 17;
    localparam int WIN = 16;
    localparam int DW  = CH * VW;

    typedef struct {
        logic [DW-1:0] val;
        logic [CH-1:0] stk;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   valid_cnt   = 0;
    int   pat_sel     = 0;
    logic [CH-1:0] pat_const = 4'b0000;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    duty_cycle_meter_mc_if #(.CHANNELS(CH), .VALUE_W(VW)) dif ();

    duty_cycle_meter_mc #(.CHANNELS(CH), .WINDOW(WIN), .VALUE_W(VW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack(input int c0, input int c1, input int c2, input int c3);
        logic [DW-1:0] r;
        r = {VW'(c3), VW'(c2), VW'(c1), VW'(c0)};
        return r;
    endfunction

    task automatic push_exp(input int c0, input int c1, input int c2, input int c3,
                            input logic [CH-1:0] stk);
        exp_t e;
        e.val = pack(c0, c1, c2, c3);
        e.stk = stk;
        sb_q.push_back(e);
    endtask

    task automatic wait_valid(input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #1;
            if (dif.valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check_val("valid_timeout", DW'(0), DW'(1));
    endtask

    task automatic wait_busy(input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #1;
            if (dif.busy === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check_val("busy_timeout", DW'(0), DW'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_value"}, dif.value, DW'(0));
        check_val({tag, "_stuck"}, DW'(dif.stuck), DW'(0));
        check_val({tag, "_valid"}, DW'(dif.valid), DW'(0));
        check_val({tag, "_busy"},  DW'(dif.busy), DW'(0));
    endtask

    // Stimulus pattern generator for ring_in, updated on the falling edge.
    initial begin : drv
        int phase;
        logic [CH-1:0] r;
        phase = 0;
        dif.ring_in = 4'b0000;
        forever begin
            @(negedge clk);
            phase++;
            r = 4'b0000;
            case (pat_sel)
                0: r = pat_const;
                1: r[2] = phase[0];
                2: r[1] = ((phase % 16) < 4);
                default: r = 4'b0000;
            endcase
            dif.ring_in = r;
        end
    end

    // Scoreboard: every valid pulse pops and compares one expected result.
    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (dif.valid === 1'b1) begin
                valid_cnt++;
                if (sb_q.size() == 0) begin
                    check_val("spurious_valid", DW'(1), DW'(0));
                end else begin
                    e = sb_q.pop_front();
                    check_val("value", dif.value, e.val);
                    check_val("stuck", DW'(dif.stuck), DW'(e.stk));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int t0, t1, v0, bn;
        reset = 1'b0;
        dif.enable = 1'b0;
        dif.mode   = 1'b0;
        dif.start  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;

        // Constant ch0 high, continuous windows
        pat_sel = 0; pat_const = 4'b0001;
        repeat (4) @(negedge clk);
        repeat (3) push_exp(16, 0, 0, 0, 4'b1111);
        dif.enable = 1'b1;
        wait_valid(40, t0);
        wait_valid(40, t1);
        check_val("cont_period", DW'(t1 - t0), DW'(WIN));
        wait_valid(40, t1);
        dif.enable = 1'b0;

        // ch2 toggling every clock
        pat_sel = 1;
        repeat (4) @(negedge clk);
        repeat (2) push_exp(0, 0, 8, 0, 4'b1011);
        dif.enable = 1'b1;
        wait_valid(40, t0);
        wait_valid(40, t1);
        dif.enable = 1'b0;

        // Single shot, ch1 high 4 of every 16 cycles
        pat_sel = 2;
        repeat (4) @(negedge clk);
        push_exp(0, 4, 0, 0, 4'b1101);
        dif.mode = 1'b1;
        dif.enable = 1'b1;
        v0 = valid_cnt;
        bn = 0;
        dif.start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) dif.start = 1'b0;
            if (dif.busy === 1'b1) bn++;
        end
        check_val("single_busy_cycles", DW'(bn), DW'(WIN));
        check_val("single_valids", DW'(valid_cnt - v0), DW'(1));
        dif.enable = 1'b0;
        dif.mode = 1'b0;

        // Abort at win_cnt=9 after one full window
        pat_sel = 0; pat_const = 4'b1010;
        repeat (4) @(negedge clk);
        push_exp(0, 16, 0, 16, 4'b1111);
        dif.enable = 1'b1;
        wait_valid(40, t0);
        repeat (9) @(posedge clk);
        #1;
        v0 = valid_cnt;
        dif.enable = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort_busy", DW'(dif.busy), DW'(0));
        repeat (30) @(negedge clk);
        check_val("abort_valids", DW'(valid_cnt - v0), DW'(0));
        check_val("abort_value_kept", dif.value, pack(0, 16, 0, 16));
        check_val("abort_stuck_kept", DW'(dif.stuck), DW'(4'b1111));

        // Reset mid-window, then restart; first window sees the synchroniser refill
        pat_const = 4'b0001;
        repeat (4) @(negedge clk);
        dif.enable = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        push_exp(15, 0, 0, 0, 4'b1110);
        push_exp(16, 0, 0, 0, 4'b1111);
        reset = 1'b1;
        wait_busy(10, t0);
        wait_valid(40, t1);
        check_val("rst_first_latency", DW'(t1 - t0), DW'(WIN));
        wait_valid(40, t1);
        dif.enable = 1'b0;

        // mode 0->1 mid-window: finish this window, then idle
        repeat (4) @(negedge clk);
        pat_const = 4'b0100;
        repeat (4) @(negedge clk);
        push_exp(0, 0, 16, 0, 4'b1111);
        dif.enable = 1'b1;
        repeat (5) @(negedge clk);
        dif.mode = 1'b1;
        wait_valid(40, t0);
        check_val("modeswitch_busy", DW'(dif.busy), DW'(0));
        @(negedge clk);
        v0 = valid_cnt;
        repeat (30) @(negedge clk);
        check_val("modeswitch_extra_valids", DW'(valid_cnt - v0), DW'(0));

        check_val("sb_drained", DW'(sb_q.size()), DW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
